onehot_dec_seq: RTL and testbench
=================================

Name: onehot_dec_seq

Overview:
Sequenced 3-to-8 decoder, the inverse of the 8-to-3 priority encoder (x[7:0] -> y[2:0], valid) used in the same design.
- Accepts 3-bit codes over a valid/ready handshake and buffers them in a small FIFO.
- Replays each buffered code as a one-hot 8-bit strobe held for HOLD cycles, with GAP idle cycles between strobes.
- Drives one-hot select/enable lines from encoded requests, for example re-expanding encoder output downstream.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
HOLD, 3, cycles each one-hot output stays asserted; >= 1
GAP, 1, idle cycles (y = 0) forced between consecutive strobes; >= 0

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_code is valid this cycle
in_code  input  3  encoded index 0..7
in_ready  output  1  FIFO can accept; equals !full
y  output  8  one-hot decoded strobe, registered
y_valid  output  1  high whenever y is non-zero
busy  output  1  high when FSM is not IDLE or FIFO is not empty
count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: on clk edge with rst = 1:
  - y = 8'h00, y_valid = 0, count = 0, in_ready = 1, busy = 0.
  - FSM returns to IDLE; read and write pointers return to 0.
  - Reset mid-strobe or mid-gap discards the current strobe and all buffered codes.
- Push: occurs on an edge when in_valid && in_ready. The code is written at the write pointer, which wraps modulo DEPTH.
- Full: when count == DEPTH, in_ready = 0 and in_valid is ignored. A pop in the same cycle does not create a push-through; in_ready is derived from the registered count only.
- Pop: only the FSM pops, per the transitions below. Simultaneous push and pop leaves count unchanged.
- FSM states:
  - IDLE: y = 0.
    - If FIFO is non-empty at the edge: pop the head, y <= 1 << code, y_valid <= 1, hold_cnt <= HOLD-1, go to DRIVE.
  - DRIVE: y is held.
    - hold_cnt != 0: decrement.
    - hold_cnt == 0 and GAP > 0: y <= 0, gap_cnt <= GAP-1, go to GAP.
    - hold_cnt == 0, GAP == 0, FIFO non-empty: pop and reload DRIVE back-to-back with the new code.
    - hold_cnt == 0, GAP == 0, FIFO empty: y <= 0, go to IDLE.
  - GAP: y = 0.
    - gap_cnt != 0: decrement.
    - gap_cnt == 0, FIFO non-empty: pop and go to DRIVE, loading as in IDLE.
    - gap_cnt == 0, FIFO empty: go to IDLE.
- Latency:
  - A code pushed into an empty FIFO while IDLE at edge N gives y_valid high after edge N+1.
  - y stays high for exactly HOLD cycles.
  - Strobe-start to strobe-start period = HOLD+GAP cycles.
- A code pushed on the same edge that IDLE samples an empty FIFO is not seen until the next edge; no bypass path.
- Counters are sized to $clog2(max(HOLD,GAP,1))+1 bits. HOLD = 1 gives a single-cycle strobe.
- y is always 0 or exactly one bit set; y_valid == |y.

Optional Feature:
ONEHOT_DEC_OVF_EN
- Defined:
  - Adds output ovf (1 bit), a sticky flag set on any edge with in_valid && !in_ready (dropped request).
  - Adds output drop_cnt (8 bits), a saturating count of dropped requests.
  - Both are cleared only by rst.
- Undefined: neither port exists; dropped requests are silently ignored (in_valid is a don't-care while in_ready is low).

Test Plan:
1. Reset with GAP = 1, HOLD = 3:
   - rst high for 2 cycles, then low; push code 5 once.
   - Required: y = 8'h20 for exactly 3 cycles starting one cycle after the push, then y = 0, count returns 0, busy falls.
2. Back-to-back, GAP = 0:
   - Push 0, 7, 3 on consecutive cycles.
   - Required: y sequence 8'h01 x3, 8'h80 x3, 8'h08 x3 with no zero cycles between strobes, then 0.
3. Full/overflow, DEPTH = 4:
   - Hold in_valid high with codes 1..6 while the first strobe is active.
   - Required: exactly 5 codes accepted (1 popped plus 4 buffered); in_ready low while count == 4; code 6 is dropped; with ONEHOT_DEC_OVF_EN, ovf = 1 and drop_cnt = 1.
4. Simultaneous push/pop:
   - count = 2 and a push lands on the edge the FSM pops.
   - Required: count stays 2; output order preserved FIFO-first.
5. Reset mid-operation:
   - Assert rst during the 2nd HOLD cycle of code 4 with 3 codes buffered.
   - Required: next cycle y = 0, count = 0, in_ready = 1; no buffered code appears afterwards.
6. Pointer wrap:
   - Stream 10 codes 0..7,0,1 with flow control honoured.
   - Required: all 10 one-hot outputs appear in order, each HOLD cycles, separated by GAP zeros.

Source files
------------

// File: rtl/onehot_dec_seq.sv
// Sequenced 3-to-8 decoder: buffers 3-bit codes in a FIFO and replays each as a one-hot strobe.
// Latency: code pushed into an empty FIFO while idle appears on y one edge later, held HOLD cycles, GAP idle cycles between strobes.
// Backpressure: in_ready = !full from the registered count; ONEHOT_DEC_OVF_EN adds ovf/drop_cnt to record dropped requests.
module onehot_dec_seq #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 3,
  parameter int GAP   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [2:0]               in_code,
  output logic                     in_ready,
  output logic [7:0]               y,
  output logic                     y_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
`ifdef ONEHOT_DEC_OVF_EN
  ,
  output logic                     ovf,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int MX0 = (HOLD > GAP) ? HOLD : GAP;
  localparam int MX  = (MX0 > 1) ? MX0 : 1;
  localparam int CW  = $clog2(MX) + 1;

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD   = (GAP > 0) ? CW'(GAP - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  state_t          state, state_nxt;
  logic [2:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   hold_cnt, hold_nxt, gap_cnt, gap_nxt;
  logic [7:0]      y_nxt;
  logic            push, pop, load, empty, full;
  logic [2:0]      head;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign y_valid  = |y;
  assign busy     = (state != S_IDLE) || !empty;

  // FIFO storage: write-only on accepted push, contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_code;
  end

  // State, strobe, counters and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      y        <= 8'h00;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      y        <= y_nxt;
      hold_cnt <= hold_nxt;
      gap_cnt  <= gap_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Next-state: pop only when the current strobe/gap has expired and the FIFO has data
  always_comb begin
    state_nxt = state;
    y_nxt     = y;
    hold_nxt  = hold_cnt;
    gap_nxt   = gap_cnt;
    load      = 1'b0;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        y_nxt = 8'h00;
        if (!empty) load = 1'b1;
      end
      S_DRIVE: begin
        if (hold_cnt != '0) begin
          hold_nxt = hold_cnt - 1'b1;
        end else if (GAP > 0) begin
          y_nxt     = 8'h00;
          gap_nxt   = GAP_LD;
          state_nxt = S_GAP;
        end else if (!empty) begin
          load = 1'b1;
        end else begin
          y_nxt     = 8'h00;
          state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        y_nxt = 8'h00;
        if (gap_cnt != '0) begin
          gap_nxt = gap_cnt - 1'b1;
        end else if (!empty) begin
          load = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        y_nxt     = 8'h00;
        state_nxt = S_IDLE;
      end
    endcase
    if (load) begin
      pop       = 1'b1;
      y_nxt     = 8'h01 << head;
      hold_nxt  = HOLD_LD;
      state_nxt = S_DRIVE;
    end
  end

`ifdef ONEHOT_DEC_OVF_EN
  // Sticky drop flag and saturating drop counter, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf      <= 1'b0;
      drop_cnt <= 8'h00;
    end else if (in_valid && !in_ready) begin
      ovf <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_onehot_dec_seq.sv
// Directed bench for onehot_dec_seq: u0 uses HOLD=3/GAP=1, u1 uses HOLD=3/GAP=0.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Each task checks its own scenario against hand-computed values.
module tb_onehot_dec_seq;

  logic       clk;
  logic       rst;
  logic       v0, v1;
  logic [2:0] c0, c1;
  logic       rdy0, rdy1, yv0, yv1, busy0, busy1;
  logic [7:0] y0, y1;
  logic [2:0] cnt0, cnt1;
`ifdef ONEHOT_DEC_OVF_EN
  logic       ovf0, ovf1;
  logic [7:0] drop0, drop1;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] ylog0[$];
  logic [7:0] ylog1[$];

  onehot_dec_seq #(.DEPTH(4), .HOLD(3), .GAP(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_code(c0), .in_ready(rdy0),
    .y(y0), .y_valid(yv0), .busy(busy0), .count(cnt0)
`ifdef ONEHOT_DEC_OVF_EN
    , .ovf(ovf0), .drop_cnt(drop0)
`endif
  );

  onehot_dec_seq #(.DEPTH(4), .HOLD(3), .GAP(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_code(c1), .in_ready(rdy1),
    .y(y1), .y_valid(yv1), .busy(busy1), .count(cnt1)
`ifdef ONEHOT_DEC_OVF_EN
    , .ovf(ovf1), .drop_cnt(drop1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    ylog0.push_back(y0);
    ylog1.push_back(y1);
  endtask

  task automatic test_reset();
    rst = 1'b1; v0 = 1'b0; c0 = 3'd0; v1 = 1'b0; c1 = 3'd0;
    tick(); tick();
    tests++;
    if (y0 !== 8'h00 || yv0 !== 1'b0 || cnt0 !== 3'd0 || rdy0 !== 1'b1 || busy0 !== 1'b0) begin
      fails++;
      $display("FAIL reset_u0 y=%h yv=%b cnt=%0d rdy=%b busy=%b, want 00 0 0 1 0", y0, yv0, cnt0, rdy0, busy0);
    end
    tests++;
    if (y1 !== 8'h00 || yv1 !== 1'b0 || cnt1 !== 3'd0 || rdy1 !== 1'b1 || busy1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_u1 y=%h yv=%b cnt=%0d rdy=%b busy=%b, want 00 0 0 1 0", y1, yv1, cnt1, rdy1, busy1);
    end
`ifdef ONEHOT_DEC_OVF_EN
    tests++;
    if (ovf0 !== 1'b0 || drop0 !== 8'd0) begin
      fails++;
      $display("FAIL reset_ovf ovf=%b drop=%0d, want 0 0", ovf0, drop0);
    end
`endif
    rst = 1'b0;
    tick();
    v0 = 1'b1; c0 = 3'd5;
    tick();
    v0 = 1'b0;
    tests++;
    if (cnt0 !== 3'd1 || y0 !== 8'h00 || busy0 !== 1'b1) begin
      fails++;
      $display("FAIL push_one cnt=%0d y=%h busy=%b, want 1 00 1", cnt0, y0, busy0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (y0 !== 8'h20 || yv0 !== 1'b1) begin
        fails++;
        $display("FAIL strobe5_cycle%0d y=%h yv=%b, want 20 1", i, y0, yv0);
      end
    end
    tick();
    tests++;
    if (y0 !== 8'h00 || yv0 !== 1'b0 || cnt0 !== 3'd0 || busy0 !== 1'b1) begin
      fails++;
      $display("FAIL strobe5_gap y=%h yv=%b cnt=%0d busy=%b, want 00 0 0 1", y0, yv0, cnt0, busy0);
    end
    tick();
    tests++;
    if (y0 !== 8'h00 || busy0 !== 1'b0) begin
      fails++;
      $display("FAIL strobe5_idle y=%h busy=%b, want 00 0", y0, busy0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [11];
    exp = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h80, 8'h80, 8'h80, 8'h08, 8'h08, 8'h08, 8'h00};
    ylog1.delete();
    v1 = 1'b1; c1 = 3'd0; tick();
    c1 = 3'd7; tick();
    c1 = 3'd3; tick();
    v1 = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 11; i++) begin
      tests++;
      if (ylog1[i] !== exp[i]) begin
        fails++;
        $display("FAIL b2b_seq[%0d] y=%h, want %h", i, ylog1[i], exp[i]);
      end
    end
    tests++;
    if (busy1 !== 1'b0 || cnt1 !== 3'd0) begin
      fails++;
      $display("FAIL b2b_end busy=%b cnt=%0d, want 0 0", busy1, cnt1);
    end
  endtask

  task automatic test_full_ovf();
    logic [7:0] starts[$];
    logic [7:0] exp_starts [5];
    int nz;
    int n40;
    exp_starts = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    nz = 0; n40 = 0;
    ylog0.delete();
    v0 = 1'b1; c0 = 3'd1; tick();
    c0 = 3'd2; tick();
    c0 = 3'd3; tick();
    c0 = 3'd4; tick();
    c0 = 3'd5; tick();
    tests++;
    if (cnt0 !== 3'd4 || rdy0 !== 1'b0) begin
      fails++;
      $display("FAIL full_state cnt=%0d rdy=%b, want 4 0", cnt0, rdy0);
    end
    c0 = 3'd6; tick();
    v0 = 1'b0;
    tests++;
    if (cnt0 !== 3'd3 || rdy0 !== 1'b1 || y0 !== 8'h04) begin
      fails++;
      $display("FAIL full_drop cnt=%0d rdy=%b y=%h, want 3 1 04", cnt0, rdy0, y0);
    end
`ifdef ONEHOT_DEC_OVF_EN
    tests++;
    if (ovf0 !== 1'b1 || drop0 !== 8'd1) begin
      fails++;
      $display("FAIL ovf_flag ovf=%b drop=%0d, want 1 1", ovf0, drop0);
    end
`endif
    repeat (16) tick();
    foreach (ylog0[i]) begin
      if (ylog0[i] != 8'h00) nz++;
      if (ylog0[i] == 8'h40) n40++;
      if (ylog0[i] != 8'h00 && (i == 0 || ylog0[i-1] != ylog0[i])) starts.push_back(ylog0[i]);
    end
    tests++;
    if (nz != 15 || n40 != 0 || starts.size() != 5) begin
      fails++;
      $display("FAIL full_accept nonzero=%0d code6_cycles=%0d strobes=%0d, want 15 0 5", nz, n40, starts.size());
    end
    for (int i = 0; i < 5 && i < starts.size(); i++) begin
      tests++;
      if (starts[i] !== exp_starts[i]) begin
        fails++;
        $display("FAIL full_order[%0d] y=%h, want %h", i, starts[i], exp_starts[i]);
      end
    end
    tests++;
    if (cnt0 !== 3'd0 || busy0 !== 1'b0) begin
      fails++;
      $display("FAIL full_drain cnt=%0d busy=%b, want 0 0", cnt0, busy0);
    end
`ifdef ONEHOT_DEC_OVF_EN
    tests++;
    if (ovf0 !== 1'b1 || drop0 !== 8'd1) begin
      fails++;
      $display("FAIL ovf_sticky ovf=%b drop=%0d, want 1 1", ovf0, drop0);
    end
`endif
  endtask

  task automatic test_simul_push_pop();
    logic [7:0] exp [18];
    exp = '{8'h00, 8'h04, 8'h04, 8'h04, 8'h00, 8'h40, 8'h40, 8'h40, 8'h00,
            8'h02, 8'h02, 8'h02, 8'h00, 8'h20, 8'h20, 8'h20, 8'h00, 8'h00};
    ylog0.delete();
    v0 = 1'b1; c0 = 3'd2; tick();
    c0 = 3'd6; tick();
    c0 = 3'd1; tick();
    v0 = 1'b0;
    tick(); tick();
    tests++;
    if (cnt0 !== 3'd2) begin
      fails++;
      $display("FAIL pp_before cnt=%0d, want 2", cnt0);
    end
    v0 = 1'b1; c0 = 3'd5; tick();
    v0 = 1'b0;
    tests++;
    if (cnt0 !== 3'd2 || y0 !== 8'h40) begin
      fails++;
      $display("FAIL pp_same_edge cnt=%0d y=%h, want 2 40", cnt0, y0);
    end
    repeat (12) tick();
    for (int i = 0; i < 18; i++) begin
      tests++;
      if (ylog0[i] !== exp[i]) begin
        fails++;
        $display("FAIL pp_seq[%0d] y=%h, want %h", i, ylog0[i], exp[i]);
      end
    end
    tests++;
    if (busy0 !== 1'b0) begin
      fails++;
      $display("FAIL pp_end busy=%b, want 0", busy0);
    end
  endtask

  task automatic test_reset_mid();
    int nz;
    nz = 0;
    v0 = 1'b1; c0 = 3'd7; tick();
    c0 = 3'd4; tick();
    c0 = 3'd1; tick();
    c0 = 3'd2; tick();
    c0 = 3'd3; tick();
    v0 = 1'b0;
    tick();
    tests++;
    if (y0 !== 8'h10) begin
      fails++;
      $display("FAIL mid_hold1 y=%h, want 10", y0);
    end
    tick();
    tests++;
    if (y0 !== 8'h10 || cnt0 !== 3'd3) begin
      fails++;
      $display("FAIL mid_hold2 y=%h cnt=%0d, want 10 3", y0, cnt0);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    tests++;
    if (y0 !== 8'h00 || yv0 !== 1'b0 || cnt0 !== 3'd0 || rdy0 !== 1'b1 || busy0 !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset y=%h yv=%b cnt=%0d rdy=%b busy=%b, want 00 0 0 1 0", y0, yv0, cnt0, rdy0, busy0);
    end
    ylog0.delete();
    repeat (12) tick();
    foreach (ylog0[i]) if (ylog0[i] != 8'h00) nz++;
    tests++;
    if (nz != 0 || busy0 !== 1'b0) begin
      fails++;
      $display("FAIL mid_flushed nonzero_cycles=%0d busy=%b, want 0 0", nz, busy0);
    end
  endtask

  task automatic test_pointer_wrap();
    logic [2:0] codes [10];
    logic [7:0] exp[$];
    logic       r;
    int         idx;
    codes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    idx = 0;
    exp.push_back(8'h00);
    for (int k = 0; k < 10; k++) begin
      for (int h = 0; h < 3; h++) exp.push_back(8'h01 << codes[k]);
      exp.push_back(8'h00);
    end
    for (int k = 0; k < 5; k++) exp.push_back(8'h00);
    ylog0.delete();
    for (int t = 0; t < 46; t++) begin
      if (idx < 10) begin
        v0 = 1'b1; c0 = codes[idx];
      end else begin
        v0 = 1'b0;
      end
      r = rdy0;
      tick();
      if (idx < 10 && r) idx++;
    end
    v0 = 1'b0;
    tests++;
    if (idx != 10) begin
      fails++;
      $display("FAIL wrap_accepted got=%0d, want 10", idx);
    end
    for (int i = 0; i < 46; i++) begin
      tests++;
      if (ylog0[i] !== exp[i]) begin
        fails++;
        $display("FAIL wrap_seq[%0d] y=%h, want %h", i, ylog0[i], exp[i]);
      end
    end
    tests++;
    if (cnt0 !== 3'd0 || busy0 !== 1'b0) begin
      fails++;
      $display("FAIL wrap_end cnt=%0d busy=%b, want 0 0", cnt0, busy0);
    end
  endtask

  initial begin
    rst = 1'b1; v0 = 1'b0; c0 = 3'd0; v1 = 1'b0; c1 = 3'd0;
    test_reset();
    test_back_to_back();
    test_full_ovf();
    test_simul_push_pop();
    test_reset_mid();
    test_pointer_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
